quad_velocity: RTL and testbench
================================

Name: quad_velocity

Overview:
Quadrature encoder decoder with per-sample-period velocity capture. It sits directly downstream of the millisecond rate pulse generator in the hba_quad peripheral, and consumes its one-clock pulse as sample_pulse. It counts x4-decoded encoder steps into a wrapping position counter. On each sample_pulse it latches the signed step count accumulated since the previous sample as the speed value, for the register/interrupt layer.

Parameters:
COUNT_WIDTH, 16, width of position counter enc_count (two's complement, wraps)
SPEED_WIDTH, 8, width of signed saturating speed value

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high reset
quad_a  input  1  encoder channel A, asynchronous to clk
quad_b  input  1  encoder channel B, asynchronous to clk
sample_pulse  input  1  one-clock strobe from rate pulse generator; latch speed
clear_count  input  1  synchronous clear of position, accumulator and error
enc_count  output  COUNT_WIDTH  signed position, x4 decoded
speed  output  SPEED_WIDTH  signed steps in last sample period, saturated
speed_valid  output  1  one-clock strobe; speed updated this cycle
dir  output  1  direction of most recent valid step (1 = forward)
err  output  1  sticky illegal-transition flag

Behaviour:
- Reset: asynchronous, active-high. All outputs, the accumulator, synchronizers, prev-state register and the warm-up counter clear to 0.
- Sync: quad_a and quad_b each pass through 2 flops (sync1, sync2). The prev register holds the last sync2 pair {a,b}.
- Warm-up: 2-bit counter runs for the first 3 cycles after reset deassert. During warm-up, prev <= sync2 and there is no counting and no err. This prevents a false step when the pins rest at a nonzero state.
- Decode each cycle, comparing prev {a,b} with sync2 {a,b}:
  - Forward (+1): 00->10, 10->11, 11->01, 01->00. Sets dir=1.
  - Reverse (-1): the inverse transitions. Sets dir=0.
  - Unchanged: 0.
  - Both bits changed: illegal. No count, err <= 1.
- prev <= sync2 every cycle.
- Latency: a pin change captured by sync1 at edge k updates enc_count/dir/err at edge k+2.
- enc_count: adds the step modulo 2^COUNT_WIDTH. 0 - 1 = all ones; max + 1 = 0.
- Accumulator: acc, SPEED_WIDTH bits signed. Adds the step, saturating at +(2^(SPEED_WIDTH-1)-1) and -(2^(SPEED_WIDTH-1)). Default limits: +127 / -128.
- sample_pulse high in cycle n: at edge n+1, speed <= sat(acc + step_n), acc <= 0, speed_valid <= 1. A step in the same cycle as the sample is included in speed, not carried over.
- speed_valid is high for exactly one cycle per sample_pulse. speed holds its value between samples.
- sample_pulse held high for consecutive cycles: each cycle latches and strobes, so the second sample reports only that cycle's step.
- clear_count: at the next edge, enc_count <= 0, acc <= 0, err <= 0. A same-cycle step is discarded. dir is unchanged.
- clear_count together with sample_pulse: clear has priority. speed <= 0, speed_valid <= 1.
- err stays set until clear_count or reset. Illegal transitions never alter enc_count or acc.
- Reset asserted mid-operation: all state clears immediately, regardless of clk. After deassert, warm-up repeats.

Test Plan:
- Forward: after warm-up, drive 10 full forward cycles (40 edges), edges 8 clk apart, then pulse sample_pulse -> enc_count=40, speed=+40, speed_valid high for exactly 1 cycle, dir=1, err=0.
- Reverse and wrap: from 0, one reverse edge (00->01) -> enc_count=16'hFFFF, dir=0. A following sample gives speed=-1 (8'hFF).
- Saturation: 200 forward edges, then sample -> speed=+127, enc_count=200. Next sample with no motion -> speed=0. Repeat with 200 reverse edges -> speed=-128.
- Illegal and clear: force 00->11 in one step -> err=1 two cycles later, enc_count unchanged. Pulse clear_count -> enc_count=0, err=0.
- Simultaneous events:
  - Sync2 step lands in the same cycle as sample_pulse, acc=5 -> speed=6, then acc=0.
  - clear_count + sample_pulse together -> speed=0, speed_valid=1.
- Reset behaviour:
  - Hold pins at 11 through reset release -> enc_count stays 0 and err stays 0 after warm-up.
  - Assert reset mid-count (enc_count=37) -> all outputs 0 immediately. Counting resumes correctly after warm-up.

Source files
------------

// File: rtl/quad_velocity.sv
// ---------------------------------------------------------------------------
// quad_velocity
//
// Quadrature encoder decoder with per-sample-period velocity capture.
// The encoder pins are synchronised, x4-decoded into single steps, and
// summed into a wrapping position counter. A saturating accumulator
// collects the steps taken since the last sample strobe. Each sample strobe
// moves the accumulator into the speed output and restarts the accumulator.
//
// Ports:
//   clk           system clock
//   reset         asynchronous, active-high reset
//   quad_a/quad_b encoder channels, asynchronous to clk
//   sample_pulse  one-clock strobe: latch speed, restart accumulation
//   clear_count   synchronous clear of position, accumulator and err
//   enc_count     signed position, x4 decoded, wraps modulo 2^COUNT_WIDTH
//   speed         signed saturated steps counted in the last sample period
//   speed_valid   one-clock strobe, high in the cycle speed was updated
//   dir           direction of the most recent valid step (1 = forward)
//   err           sticky illegal-transition flag
// ---------------------------------------------------------------------------
module quad_velocity #(
    parameter int COUNT_WIDTH = 16,
    parameter int SPEED_WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   quad_a,
    input  logic                   quad_b,
    input  logic                   sample_pulse,
    input  logic                   clear_count,
    output logic [COUNT_WIDTH-1:0] enc_count,
    output logic [SPEED_WIDTH-1:0] speed,
    output logic                   speed_valid,
    output logic                   dir,
    output logic                   err
);

    // Decoder holds off for three cycles after reset so that pins resting
    // at a nonzero state are absorbed into prev without producing a step.
    localparam logic [1:0] WARM_DONE = 2'd3;

    // Saturating add of a single step (-1, 0, +1) onto a speed-width value.
    // The extra sign bit of the sum tells overflow apart from a valid result.
    function automatic logic signed [SPEED_WIDTH-1:0] sat_add(
        input logic signed [SPEED_WIDTH-1:0] a,
        input logic signed [1:0]             s
    );
        logic [SPEED_WIDTH:0] sum;
        logic signed [SPEED_WIDTH-1:0] res;
        sum = {a[SPEED_WIDTH-1], a} + {{(SPEED_WIDTH-1){s[1]}}, s};
        if (sum[SPEED_WIDTH] != sum[SPEED_WIDTH-1]) begin
            if (sum[SPEED_WIDTH] == 1'b0) begin
                res = {1'b0, {(SPEED_WIDTH-1){1'b1}}};
            end else begin
                res = {1'b1, {(SPEED_WIDTH-1){1'b0}}};
            end
        end else begin
            res = sum[SPEED_WIDTH-1:0];
        end
        return res;
    endfunction

    // Sign-extends a single step to the position counter width.
    function automatic logic [COUNT_WIDTH-1:0] step_ext(
        input logic signed [1:0] s
    );
        return {{(COUNT_WIDTH-2){s[1]}}, s};
    endfunction

    logic                          sync1_a, sync1_b;
    logic                          sync2_a, sync2_b;
    logic                          prev_a, prev_b;
    logic [1:0]                    warm_cnt;
    logic                          decode_en;

    logic                          fwd_p2;
    logic                          rev_p2;
    logic                          ill_p2;
    logic signed [1:0]             step_p2;

    logic signed [SPEED_WIDTH-1:0] acc;
    logic signed [SPEED_WIDTH-1:0] acc_sum;

    assign decode_en = (warm_cnt == WARM_DONE);

    // ---- stage 2: compare the synchronised pair against the previous pair
    always_comb begin
        fwd_p2  = 1'b0;
        rev_p2  = 1'b0;
        ill_p2  = 1'b0;
        step_p2 = 2'sd0;
        if (decode_en) begin
            case ({prev_a, prev_b, sync2_a, sync2_b})
                4'b0010, 4'b1011, 4'b1101, 4'b0100: fwd_p2 = 1'b1;
                4'b1000, 4'b1110, 4'b0111, 4'b0001: rev_p2 = 1'b1;
                4'b0011, 4'b1100, 4'b0110, 4'b1001: ill_p2 = 1'b1;
                default: ;
            endcase
        end
        if (fwd_p2) begin
            step_p2 = 2'sd1;
        end else if (rev_p2) begin
            step_p2 = -2'sd1;
        end
    end

    // Accumulator including this cycle's step; a step landing in the same
    // cycle as a sample belongs to the period being reported.
    assign acc_sum = sat_add(acc, step_p2);

    // ---- stage 0/1: two-flop synchronisers, prev register, warm-up counter
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_a  <= 1'b0;
            sync1_b  <= 1'b0;
            sync2_a  <= 1'b0;
            sync2_b  <= 1'b0;
            prev_a   <= 1'b0;
            prev_b   <= 1'b0;
            warm_cnt <= 2'd0;
        end else begin
            sync1_a <= quad_a;
            sync1_b <= quad_b;
            sync2_a <= sync1_a;
            sync2_b <= sync1_b;
            prev_a  <= sync2_a;
            prev_b  <= sync2_b;
            if (warm_cnt != WARM_DONE) begin
                warm_cnt <= warm_cnt + 2'd1;
            end
        end
    end

    // ---- stage 3: position, accumulator, speed capture and status flags
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            enc_count   <= '0;
            acc         <= '0;
            speed       <= '0;
            speed_valid <= 1'b0;
            dir         <= 1'b0;
            err         <= 1'b0;
        end else begin
            speed_valid <= sample_pulse;
            if (clear_count) begin
                // Clear wins over any step or sample in the same cycle;
                // dir keeps the last direction seen.
                enc_count <= '0;
                acc       <= '0;
                err       <= 1'b0;
                if (sample_pulse) begin
                    speed <= '0;
                end
            end else begin
                if (fwd_p2 || rev_p2) begin
                    enc_count <= enc_count + step_ext(step_p2);
                    dir       <= fwd_p2;
                end
                if (ill_p2) begin
                    err <= 1'b1;
                end
                if (sample_pulse) begin
                    speed <= acc_sum;
                    acc   <= '0;
                end else begin
                    acc <= acc_sum;
                end
            end
        end
    end

endmodule

// File: tb/tb_quad_velocity.sv
// ---------------------------------------------------------------------------
// tb_quad_velocity
//
// Directed bench for quad_velocity: drives quadrature edge sequences,
// sample and clear strobes, and resets, and compares outputs against
// hand-computed values.
// ---------------------------------------------------------------------------
module tb_quad_velocity;

    logic        clk;
    logic        reset;
    logic        quad_a;
    logic        quad_b;
    logic        sample_pulse;
    logic        clear_count;
    logic [15:0] enc_count;
    logic [7:0]  speed;
    logic        speed_valid;
    logic        dir;
    logic        err;

    int vectors;
    int miscompares;

    // Forward sequence of pin states {a,b}: 00 -> 10 -> 11 -> 01 -> 00
    logic [1:0] seq [4];
    int         idx;

    quad_velocity #(
        .COUNT_WIDTH(16),
        .SPEED_WIDTH(8)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .quad_a      (quad_a),
        .quad_b      (quad_b),
        .sample_pulse(sample_pulse),
        .clear_count (clear_count),
        .enc_count   (enc_count),
        .speed       (speed),
        .speed_valid (speed_valid),
        .dir         (dir),
        .err         (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // All tasks start and end 1 time unit after a rising clock edge.
    task automatic set_pins();
        quad_a = seq[idx][1];
        quad_b = seq[idx][0];
    endtask

    task automatic fwd_edge(input int gap);
        idx = (idx + 1) % 4;
        set_pins();
        repeat (gap) @(posedge clk);
        #1;
    endtask

    task automatic rev_edge(input int gap);
        idx = (idx + 3) % 4;
        set_pins();
        repeat (gap) @(posedge clk);
        #1;
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Pulses sample_pulse for one cycle and checks the captured speed.
    task automatic sample_check(input string tag, input logic [7:0] exp_speed);
        sample_pulse = 1'b1;
        tick(1);
        sample_pulse = 1'b0;
        chk({tag, "_speed"}, speed, exp_speed);
        chk({tag, "_valid"}, speed_valid, 1'b1);
        tick(1);
        chk({tag, "_valid_drop"}, speed_valid, 1'b0);
        chk({tag, "_speed_hold"}, speed, exp_speed);
    endtask

    task automatic clear_pulse();
        clear_count = 1'b1;
        tick(1);
        clear_count = 1'b0;
    endtask

    initial begin
        vectors      = 0;
        miscompares  = 0;
        seq[0]       = 2'b00;
        seq[1]       = 2'b10;
        seq[2]       = 2'b11;
        seq[3]       = 2'b01;
        idx          = 0;
        reset        = 1'b1;
        quad_a       = 1'b0;
        quad_b       = 1'b0;
        sample_pulse = 1'b0;
        clear_count  = 1'b0;

        // Reset state
        tick(1);
        chk("rst_count", enc_count, 16'h0000);
        chk("rst_speed", speed, 8'h00);
        chk("rst_valid", speed_valid, 1'b0);
        chk("rst_dir", dir, 1'b0);
        chk("rst_err", err, 1'b0);
        reset = 1'b0;
        tick(5);

        // Forward: 40 edges, 8 clocks apart
        for (int i = 0; i < 40; i++) fwd_edge(8);
        chk("fwd_count", enc_count, 16'd40);
        chk("fwd_dir", dir, 1'b1);
        chk("fwd_err", err, 1'b0);
        sample_check("fwd", 8'd40);

        // Reverse and wrap from zero
        clear_pulse();
        chk("clr_count", enc_count, 16'h0000);
        rev_edge(4);
        chk("rev_count", enc_count, 16'hFFFF);
        chk("rev_dir", dir, 1'b0);
        sample_check("rev", 8'hFF);

        // Saturation, forward then reverse
        clear_pulse();
        for (int i = 0; i < 200; i++) fwd_edge(4);
        chk("satp_count", enc_count, 16'd200);
        sample_check("satp", 8'h7F);
        sample_check("idle", 8'h00);
        for (int i = 0; i < 200; i++) rev_edge(4);
        chk("satn_count", enc_count, 16'h0000);
        chk("satn_dir", dir, 1'b0);
        sample_check("satn", 8'h80);

        // Illegal transition: both bits change in one step
        clear_pulse();
        fwd_edge(4);
        chk("pre_ill_count", enc_count, 16'd1);
        idx = (idx + 2) % 4;
        set_pins();
        tick(2);
        chk("ill_latency", err, 1'b0);
        tick(1);
        chk("ill_err", err, 1'b1);
        chk("ill_count", enc_count, 16'd1);
        tick(4);
        chk("ill_sticky", err, 1'b1);
        clear_pulse();
        chk("ill_clr_count", enc_count, 16'h0000);
        chk("ill_clr_err", err, 1'b0);

        // Step landing in the same cycle as sample_pulse, acc = 5
        for (int i = 0; i < 5; i++) fwd_edge(4);
        idx = (idx + 1) % 4;
        set_pins();
        tick(2);
        sample_pulse = 1'b1;
        tick(1);
        sample_pulse = 1'b0;
        chk("same_speed", speed, 8'd6);
        chk("same_valid", speed_valid, 1'b1);
        chk("same_count", enc_count, 16'd6);
        tick(3);
        sample_check("same_after", 8'h00);

        // clear_count together with sample_pulse
        for (int i = 0; i < 3; i++) fwd_edge(4);
        chk("cs_pre_count", enc_count, 16'd9);
        clear_count  = 1'b1;
        sample_pulse = 1'b1;
        tick(1);
        clear_count  = 1'b0;
        sample_pulse = 1'b0;
        chk("cs_speed", speed, 8'h00);
        chk("cs_valid", speed_valid, 1'b1);
        chk("cs_count", enc_count, 16'h0000);
        chk("cs_dir", dir, 1'b1);

        // Pins resting at 11 through reset release
        #2 reset = 1'b1;
        #1;
        chk("rst2_dir", dir, 1'b0);
        idx = 2;
        set_pins();
        tick(3);
        reset = 1'b0;
        tick(10);
        chk("rest11_count", enc_count, 16'h0000);
        chk("rest11_err", err, 1'b0);

        // Reset mid-count, asynchronous to the clock
        for (int i = 0; i < 37; i++) fwd_edge(4);
        chk("mid_count", enc_count, 16'd37);
        chk("mid_dir", dir, 1'b1);
        #2 reset = 1'b1;
        #1;
        chk("async_count", enc_count, 16'h0000);
        chk("async_dir", dir, 1'b0);
        chk("async_speed", speed, 8'h00);
        chk("async_err", err, 1'b0);
        tick(2);
        reset = 1'b0;
        tick(6);
        chk("resume_idle", enc_count, 16'h0000);
        for (int i = 0; i < 3; i++) fwd_edge(4);
        chk("resume_count", enc_count, 16'd3);
        chk("resume_dir", dir, 1'b1);
        chk("resume_err", err, 1'b0);
        sample_check("resume", 8'd3);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
